// File: rtl/life_engine.sv
// rtl/life_engine.sv - B3/S23 Game of Life grid engine with step/run modes, generation counter and auto-halt.
// Optional macro LIFE_TORUS_EN: wrap neighbours around the grid edges; undefined treats off-grid cells as dead.
module life_engine #(
  parameter int ROWS  = 8,
  parameter int COLS  = 8,
  parameter int GEN_W = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 load,
  input  logic [ROWS*COLS-1:0] seed_in,
  input  logic                 step,
  input  logic                 run,
  output logic [ROWS*COLS-1:0] grid_out,
  output logic [GEN_W-1:0]     gen_count,
  output logic                 running,
  output logic                 stable,
  output logic                 extinct
);

  localparam int N = ROWS * COLS;

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_HALT
  } state_t;

  state_t           state_q, state_d;
  logic [N-1:0]     grid_q, grid_d;
  logic [N-1:0]     next_grid;
  logic [GEN_W-1:0] gen_q, gen_d;
  logic             stable_q, stable_d;
  logic             advance;
  logic             no_change;

  // Per-cell neighbour gather, 4-bit adder tree and B3/S23 rule, all resolved at elaboration.
  for (genvar r = 0; r < ROWS; r++) begin : g_row
    for (genvar c = 0; c < COLS; c++) begin : g_col
      logic [7:0] nb;
      logic [1:0] s0, s1, s2, s3;
      logic [2:0] t0, t1;
      logic [3:0] n;

      for (genvar k = 0; k < 9; k++) begin : g_nb
        if (k != 4) begin : g_use
          localparam int B      = (k < 4) ? k : k - 1;
          localparam int RR_RAW = r + (k / 3) - 1;
          localparam int CC_RAW = c + (k % 3) - 1;
`ifdef LIFE_TORUS_EN
          localparam int RR = (RR_RAW + ROWS) % ROWS;
          localparam int CC = (CC_RAW + COLS) % COLS;
          assign nb[B] = grid_q[RR*COLS + CC];
`else
          if (RR_RAW >= 0 && RR_RAW < ROWS && CC_RAW >= 0 && CC_RAW < COLS) begin : g_in
            assign nb[B] = grid_q[RR_RAW*COLS + CC_RAW];
          end else begin : g_out
            assign nb[B] = 1'b0;
          end
`endif
        end
      end

      assign s0 = {1'b0, nb[0]} + {1'b0, nb[1]};
      assign s1 = {1'b0, nb[2]} + {1'b0, nb[3]};
      assign s2 = {1'b0, nb[4]} + {1'b0, nb[5]};
      assign s3 = {1'b0, nb[6]} + {1'b0, nb[7]};
      assign t0 = {1'b0, s0} + {1'b0, s1};
      assign t1 = {1'b0, s2} + {1'b0, s3};
      assign n  = {1'b0, t0} + {1'b0, t1};

      assign next_grid[r*COLS + c] = (n == 4'd3) | (grid_q[r*COLS + c] & (n == 4'd2));
    end
  end

  assign no_change = (next_grid == grid_q);

  always_comb begin
    state_d  = state_q;
    grid_d   = grid_q;
    gen_d    = gen_q;
    stable_d = stable_q;
    advance  = 1'b0;

    if (load) begin
      state_d  = S_IDLE;
      grid_d   = seed_in;
      gen_d    = '0;
      stable_d = 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (run) begin
            advance = 1'b1;
            state_d = S_RUN;
          end else if (step) begin
            advance = 1'b1;
          end
        end
        S_RUN: begin
          if (run) advance = 1'b1;
          else     state_d = S_IDLE;
        end
        S_HALT:  ;
        default: state_d = S_IDLE;
      endcase

      // An advance that changes nothing (including an empty grid) freezes the engine.
      if (advance) begin
        grid_d   = next_grid;
        stable_d = no_change;
        if (gen_q != '1) gen_d = gen_q + GEN_W'(1);
        if (no_change) state_d = S_HALT;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= S_IDLE;
      grid_q   <= '0;
      gen_q    <= '0;
      stable_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      grid_q   <= grid_d;
      gen_q    <= gen_d;
      stable_q <= stable_d;
    end
  end

  assign grid_out  = grid_q;
  assign gen_count = gen_q;
  assign running   = (state_q == S_RUN);
  assign stable    = stable_q;
  assign extinct   = ~|grid_q;

endmodule

// File: doc/life_engine.md
Name: life_engine

Overview:
- Parametrised Conway Game of Life engine holding a ROWS x COLS grid in registers.
- Computes one generation per advance cycle using the B3/S23 rule.
- Supports single-step and free-run modes, a generation counter, and stable/extinct detection with automatic halt.
- Successor to the fixed 8x8 life block; sits between the seed source (switches/host) and the display driver.

Parameters:
ROWS, 8, grid height in cells (>=3)
COLS, 8, grid width in cells (>=3)
GEN_W, 16, width of generation counter

Ports:
clk  input  1  system clock, all state on rising edge
reset  input  1  asynchronous active-high reset
load  input  1  synchronous pulse: copy seed_in into grid
seed_in  input  ROWS*COLS  initial pattern; bit r*COLS+c is row r, col c (bit 0 = row 0 col 0)
step  input  1  advance exactly one generation (level sampled per cycle, used in IDLE only)
run  input  1  level: free-run, one generation per cycle
grid_out  output  ROWS*COLS  current grid register, same bit mapping
gen_count  output  GEN_W  generations computed since last load/reset
running  output  1  high while in RUN state
stable  output  1  last advance produced no change
extinct  output  1  grid_out is all zeros (combinational from grid register)

Behaviour:
- Reset (async, any time incl. mid-run): grid=0, gen_count=0, stable=0, state=IDLE, running=0; extinct therefore reads 1.
- Next-state rule per cell: count of 8 neighbours n (0..8, 4-bit adder tree). Live cell survives iff n==2 or n==3; dead cell born iff n==3.
- Edge handling: out-of-grid neighbours are dead (torus only with TORUS_EN).
- "Advance": grid<=next_grid; gen_count<=gen_count+1, saturating at 2^GEN_W-1; stable<=(next_grid==grid). Grid update visible on grid_out the cycle after the advancing edge (1-cycle latency).
- Priority each cycle: reset > load > run/step.
- load (any state): grid<=seed_in, gen_count<=0, stable<=0, state<=IDLE. No advance that cycle.
- FSM states: IDLE, RUN, HALT.
- IDLE: if run=1, advance and go to RUN. Else if step=1, advance and stay in IDLE. Else hold. step and run both high behaves as run.
- RUN: running=1. If run=1, advance every cycle. If run=0, go to IDLE with no advance.
- Stability halt: any advance with next_grid==grid sets stable=1 and moves to HALT (from IDLE or RUN). Covers extinct grids.
- HALT: grid and gen_count frozen; step/run ignored; only load or reset exits.
- Holding step high in IDLE advances once per cycle (no edge detect; edge detection belongs to the debounce upstream).

Optional Feature:
- Macro: LIFE_TORUS_EN.
- Defined: grid is toroidal. Neighbour row index wraps (r-1 mod ROWS, r+1 mod ROWS), and likewise for columns.
- Undefined: cells beyond edges are treated as dead.
- All other behaviour is identical.

Test Plan:
- Reset mid-RUN with run=1 -> same cycle grid_out=0, gen_count=0, running=0, extinct=1; after release with run still high, state stays RUN only via IDLE->RUN with zero grid, which immediately halts with stable=1.
- Blinker: load bits {26,27,28}, pulse step one cycle -> grid_out={19,27,35}, gen_count=1, stable=0; second step -> {26,27,28}, gen_count=2.
- Block still life: load bits {9,10,17,18}, assert run -> after 1 advance grid unchanged, stable=1, state HALT, running=0, gen_count=1; further run/step leave gen_count=1.
- Saturation: GEN_W=4, blinker, run held 20 cycles -> gen_count stops at 15, grid keeps oscillating.
- LIFE_TORUS_EN defined, glider {1,10,16,17,18}, run 32 cycles -> grid_out equals seed again, gen_count=32, stable=0. Undefined, same stimulus -> grid differs from seed at gen 32.
- load during RUN with run=1 -> next cycle grid=seed_in, gen_count=0, state IDLE; following cycle re-enters RUN and advances.
